// File: rtl/qtag.sv
// qtag: merges two eot-delimited queue streams into one tagged stream.
// Output word layout is {eot, ctrl, data}. ctrl is the source index, and the
// source data is zero-extended to W_DOUT.
// Once a source wins arbitration, it keeps the output until it sends a word
// with all eot bits set.
// Optional feature: define QTAG_RR_EN to use round-robin arbitration on IDLE
// conflicts. When it is undefined, din0 has fixed priority.
//
// state | meaning
// IDLE  | no open transaction; arbitrate between valid inputs
// LOCK0 | din0 transaction open; only din0 may transfer
// LOCK1 | din1 transaction open; only din1 may transfer
module qtag #(
  parameter int W_DIN0 = 16,
  parameter int W_DIN1 = 16,
  parameter int W_DOUT = 16,
  parameter int LVL    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [LVL+W_DIN0-1:0]   i_din0_data,
  input  logic                    i_din0_valid,
  output logic                    o_din0_ready,
  input  logic [LVL+W_DIN1-1:0]   i_din1_data,
  input  logic                    i_din1_valid,
  output logic                    o_din1_ready,
  output logic [LVL+W_DOUT:0]     o_dout_data,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready
);

  generate
    if (W_DOUT < W_DIN0 || W_DOUT < W_DIN1) begin : g_width_err
      $error("qtag: W_DOUT must be >= max(W_DIN0, W_DIN1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic [LVL+W_DOUT:0]    r_data;

  logic                   w_prio;
  logic                   w_load_ok;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_acc0;
  logic                   w_acc1;
  logic [LVL-1:0]         w_eot0;
  logic [LVL-1:0]         w_eot1;
  logic                   w_end0;
  logic                   w_end1;
  logic [LVL+W_DOUT:0]    w_word0;
  logic [LVL+W_DOUT:0]    w_word1;

`ifdef QTAG_RR_EN
  logic                   r_prio;
  assign w_prio = r_prio;
`else
  assign w_prio = 1'b0;
`endif

  assign w_eot0  = i_din0_data[LVL+W_DIN0-1:W_DIN0];
  assign w_eot1  = i_din1_data[LVL+W_DIN1-1:W_DIN1];
  assign w_end0  = &w_eot0;
  assign w_end1  = &w_eot1;
  assign w_word0 = {w_eot0, 1'b0, W_DOUT'(i_din0_data[W_DIN0-1:0])};
  assign w_word1 = {w_eot1, 1'b1, W_DOUT'(i_din1_data[W_DIN1-1:0])};

  // The output register can accept a word when it is empty or is draining this cycle.
  assign w_load_ok = !r_valid || i_dout_ready;

  // Grant: a locked source keeps the grant; otherwise arbitrate in the same cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt0 = i_din0_valid && (!i_din1_valid || !w_prio);
        w_gnt1 = i_din1_valid && (!i_din0_valid ||  w_prio);
      end
      LOCK0:   w_gnt0 = 1'b1;
      LOCK1:   w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  // Ready is forced low while reset is asserted, even before the first clock edge.
  assign o_din0_ready = i_rst_n && w_gnt0 && w_load_ok;
  assign o_din1_ready = i_rst_n && w_gnt1 && w_load_ok;
  assign w_acc0       = o_din0_ready && i_din0_valid;
  assign w_acc1       = o_din1_ready && i_din1_valid;

  assign o_dout_valid = r_valid && i_rst_n;
  assign o_dout_data  = r_data;

  // Arbitration FSM, output register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef QTAG_RR_EN
      r_prio  <= 1'b0;
`endif
    end else begin
      if (w_acc0) begin
        r_data  <= w_word0;
        r_valid <= 1'b1;
        r_state <= w_end0 ? IDLE : LOCK0;
      end else if (w_acc1) begin
        r_data  <= w_word1;
        r_valid <= 1'b1;
        r_state <= w_end1 ? IDLE : LOCK1;
      end else if (i_dout_ready) begin
        r_valid <= 1'b0;
      end
`ifdef QTAG_RR_EN
      if (w_acc0 && w_end0) begin
        r_prio <= 1'b1;
      end else if (w_acc1 && w_end1) begin
        r_prio <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_qtag.sv
// Bench for qtag with W_DIN1=8 and LVL=2. The first part is directed, with
// literal expectations; the second part uses random stimulus. A transaction-level
// model predicts ready, valid and data on every cycle.
module tb_qtag;

  localparam int W0 = 16;
  localparam int W1 = 8;
  localparam int WO = 16;
  localparam int L  = 2;
  localparam int WD = L + 1 + WO;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [L+W0-1:0] d0;
  logic            v0;
  logic            r0;
  logic [L+W1-1:0] d1;
  logic            v1;
  logic            r1;
  logic [WD-1:0]   dout;
  logic            dv;
  logic            dr;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  bit s_acc0   = 1'b0;
  bit s_acc1   = 1'b0;

  int            m_owner = -1;
  int            m_turn  = 0;
  bit            m_ov    = 1'b0;
  logic [WD-1:0] m_od    = '0;

  qtag #(.W_DIN0(W0), .W_DIN1(W1), .W_DOUT(WO), .LVL(L)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_din0_data  (d0),
    .i_din0_valid (v0),
    .o_din0_ready (r0),
    .i_din1_data  (d1),
    .i_din1_valid (v1),
    .o_din1_ready (r1),
    .o_dout_data  (dout),
    .o_dout_valid (dv),
    .i_dout_ready (dr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Which source may transfer this cycle: the open transaction's owner, or the arbitration winner.
  function automatic bit exp_rdy(input int src);
    int pick;
    if (!rst_n) return 1'b0;
    if (m_ov && !dr) return 1'b0;
    if (m_owner != -1) return m_owner == src;
    if (v0 && v1)  pick = m_turn;
    else if (v0)   pick = 0;
    else if (v1)   pick = 1;
    else           pick = -1;
    return pick == src;
  endfunction

  function automatic logic [WD-1:0] mk0(input logic [L+W0-1:0] w);
    logic [WO-1:0] z;
    z = '0;
    z[W0-1:0] = w[W0-1:0];
    return {w[L+W0-1:W0], 1'b0, z};
  endfunction

  function automatic logic [WD-1:0] mk1(input logic [L+W1-1:0] w);
    logic [WO-1:0] z;
    z = '0;
    z[W1-1:0] = w[W1-1:0];
    return {w[L+W1-1:W1], 1'b1, z};
  endfunction

  // Model update at each clock edge, using the pre-edge model state.
  always @(posedge clk) begin
    bit a0, a1;
    a0 = v0 && exp_rdy(0);
    a1 = v1 && exp_rdy(1);
    if (!rst_n) begin
      cmp_en  <= 1'b1;
      m_owner <= -1;
      m_turn  <= 0;
      m_ov    <= 1'b0;
      m_od    <= '0;
    end else if (a0) begin
      m_od <= mk0(d0);
      m_ov <= 1'b1;
      if (&d0[L+W0-1:W0]) begin
        m_owner <= -1;
`ifdef QTAG_RR_EN
        m_turn  <= 1;
`endif
      end else begin
        m_owner <= 0;
      end
    end else if (a1) begin
      m_od <= mk1(d1);
      m_ov <= 1'b1;
      if (&d1[L+W1-1:W1]) begin
        m_owner <= -1;
`ifdef QTAG_RR_EN
        m_turn  <= 0;
`endif
      end else begin
        m_owner <= 1;
      end
    end else if (dr) begin
      m_ov <= 1'b0;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    s_acc0 <= v0 && r0;
    s_acc1 <= v1 && r1;
    if (cmp_en) begin
      chk("din0_ready", r0, exp_rdy(0));
      chk("din1_ready", r1, exp_rdy(1));
      chk("dout_valid", dv, rst_n && m_ov);
      if (rst_n) chk("dout_data", dout, m_od);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_word0();
    v0 = ($urandom % 4) != 0;
    d0[W0-1:0] = W0'($urandom);
    d0[L+W0-1:W0] = (($urandom % 3) == 0) ? 2'b11 : 2'($urandom);
  endtask

  task automatic new_word1();
    v1 = ($urandom % 4) != 0;
    d1[W1-1:0] = W1'($urandom);
    d1[L+W1-1:W1] = (($urandom % 3) == 0) ? 2'b11 : 2'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [WD-1:0] held;
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; dr = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", dv, 0);
    chk("rst_data", dout, 0);

    // Three-word din0 transaction.
    tick();
    v0 = 1'b1; d0 = {2'b00, 16'h0011};
    @(negedge clk); chk("a_ready0", r0, 1);
    tick(); d0 = {2'b00, 16'h0022};
    @(negedge clk); chk("a_w0", dout, 19'h00011);
    tick(); d0 = {2'b11, 16'h0033};
    @(negedge clk); chk("a_w1", dout, 19'h00022);
    tick(); v0 = 1'b0;
    @(negedge clk); chk("a_w2", dout, 19'h60033); chk("a_w2v", dv, 1);
    tick();
    @(negedge clk); chk("a_empty", dv, 0);

    // din1 holds the lock while din0 is requesting.
    tick();
    v1 = 1'b1; d1 = {2'b00, 8'hA5};
    tick();
    v0 = 1'b1; d0 = {2'b11, 16'h0077}; d1 = {2'b11, 8'h5A};
    @(negedge clk); chk("b_lock_r0", r0, 0); chk("b_lock_r1", r1, 1); chk("b_w0", dout, 19'h100A5);
    tick(); v1 = 1'b0;
    @(negedge clk); chk("b_free_r0", r0, 1); chk("b_w1", dout, 19'h7005A);
    tick(); v0 = 1'b0;
    @(negedge clk); chk("b_w2", dout, 19'h60077);

    // Contention with single-word transactions starting from reset.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    v0 = 1'b1; v1 = 1'b1; d0 = {2'b11, 16'h0101}; d1 = {2'b11, 8'h02};
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
`ifdef QTAG_RR_EN
      chk("c_ctrl", dout[WO], 1'(i % 2));
`else
      chk("c_ctrl", dout[WO], 0);
`endif
    end

    // Output stall with a valid word held.
    tick(); dr = 1'b0;
    @(negedge clk); held = dout; chk("d_valid", dv, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("d_hold", dout, held); chk("d_r0", r0, 0); chk("d_r1", r1, 0);
    end
    tick(); dr = 1'b1;
    repeat (3) tick();
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) tick();

    // A two-bit eot: the lock holds through eot=01 and releases after eot=11.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    v0 = 1'b1; d0 = {2'b01, 16'h00AA}; v1 = 1'b1; d1 = {2'b11, 8'h33};
    @(negedge clk); chk("e_r0", r0, 1); chk("e_r1", r1, 0);
    tick(); d0 = {2'b11, 16'h00BB};
    @(negedge clk); chk("e_lock_r1", r1, 0);
    tick(); v0 = 1'b0;
    @(negedge clk); chk("e_rel_r1", r1, 1);
    tick(); v1 = 1'b0;
    repeat (2) tick();

    // Reset mid-transaction with a valid output word.
    v0 = 1'b1; d0 = {2'b00, 16'h0012};
    tick(); rst_n = 1'b0;
    @(negedge clk); chk("f_rst_v", dv, 0); chk("f_rst_r0", r0, 0); chk("f_rst_r1", r1, 0);
    tick(); rst_n = 1'b1; v0 = 1'b0; v1 = 1'b1; d1 = {2'b11, 8'h44};
    @(negedge clk); chk("f_post_v", dv, 0); chk("f_post_r1", r1, 1);
    tick(); v1 = 1'b0;
    @(negedge clk); chk("f_w", dout, 19'h70044);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!v0 || s_acc0) new_word0();
      if (!v1 || s_acc1) new_word1();
      dr    = ($urandom % 4) != 0;
      rst_n = ($urandom % 300) != 0;
    end
    rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0; dr = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qtag.md
QTAG -- requirements
Module: qtag

Interface
REQ-001 Parameter W_DIN0, default 16: data width of din0, excluding eot.
REQ-002 Parameter W_DIN1, default 16: data width of din1, excluding eot.
REQ-003 Parameter W_DOUT, default 16: data width of dout; SHALL be >= max(W_DIN0, W_DIN1), elaboration error otherwise.
REQ-004 Parameter LVL, default 1: eot width of the queue on all ports.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 din0  dti.consumer  LVL+W_DIN0  queue stream, layout {eot[LVL-1:0], data}; tagged ctrl=0.
REQ-008 din1  dti.consumer  LVL+W_DIN1  queue stream, same layout; tagged ctrl=1.
REQ-009 dout  dti.producer  LVL+1+W_DOUT  tagged union queue, layout {eot[LVL-1:0], ctrl, data}.

Function
REQ-010 Block SHALL merge two queue streams into one tagged stream: the inverse of the union field filter.
REQ-011 Transaction end SHALL be a transferred input word with all eot bits set (&eot).
REQ-012 FSM states: IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-013 IDLE: only din0 valid -> grant din0; only din1 valid -> grant din1; both valid -> grant the input pointed to by prio; none -> stay IDLE.
REQ-014 Grant SHALL take effect in the same cycle: the granted word is accepted in that cycle if the output register can load.
REQ-015 After an accepted granted word: with &eot=1 -> IDLE; otherwise -> LOCK0/LOCK1 matching the source.
REQ-016 LOCKn SHALL accept only dinn; the other input SHALL see ready=0 until dinn transfers a word with &eot=1, then -> IDLE.
REQ-017 din ready: dinn.ready = granted_or_locked_n && load_ok; load_ok = !out_valid || dout.ready.
REQ-018 Output register: one word; loaded on accepted input; dout.valid from register; latency 1 cycle; throughput 1 word/cycle under continuous ready.
REQ-019 dout.data SHALL be {eot of source, ctrl = source index, source data zero-extended to W_DOUT}.
REQ-020 Simultaneous output handshake and load SHALL replace the register contents with no bubble; handshake without load SHALL clear out_valid.
REQ-021 dout.valid SHALL NOT depend combinationally on any din.valid; dout SHALL hold data and valid stable while valid && !ready.
REQ-022 prio SHALL toggle to the non-granted input at every transaction end (see REQ-029).
REQ-023 A single-word transaction (&eot=1 on first word) SHALL pass through IDLE without entering LOCK.

Reset
REQ-024 While rst=0 at posedge: state=IDLE, prio=din0, out_valid=0, output register data=0.
REQ-025 During and immediately after reset: dout.valid=0, din0.ready=0, din1.ready=0 combinationally while rst=0.
REQ-026 Reset mid-transaction SHALL discard the registered word and the lock; the next transaction arbitrates fresh from IDLE.

Configuration
REQ-027 Macro QTAG_RR_EN selects the arbitration policy.
REQ-028 Without QTAG_RR_EN: fixed priority; din0 SHALL win every IDLE conflict; prio register not implemented.
REQ-029 With QTAG_RR_EN: round-robin per REQ-022; prio resets to din0.

Verification
REQ-030 din0 sends 3 words, eot=0,0,1, data 0x11,0x22,0x33; dout.ready=1 -> dout = {0,0,0x11},{0,0,0x22},{1,0,0x33}, each 1 cycle after acceptance.
REQ-031 din1 mid-transaction while din0 asserts valid; W_DIN1=8, data 0xA5 -> din0.ready=0 until din1 eot word; dout data 0x00A5, ctrl=1.
REQ-032 Both valid in IDLE, 1-word transactions repeated, QTAG_RR_EN defined -> ctrl alternates 0,1,0,1; undefined -> ctrl stays 0 while din0 valid.
REQ-033 dout.ready=0 for 4 cycles with output valid -> dout stable, din ready=0; ready released -> one word per cycle, no loss or duplication.
REQ-034 LVL=2; din0 words with eot=01 then 11 -> lock held through eot=01, released after eot=11.
REQ-035 rst=0 asserted with a locked transaction and valid output -> next cycle dout.valid=0, state IDLE; din1 then wins an uncontested grant.
